// File: rtl/mem_store_unit.sv
// Byte-serial store unit: emits SB/SH/SW requests as little-endian byte writes
// on the shared 8-bit memory bus, one byte per granted cycle.
module mem_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_data_i,
  input  logic [1:0]        req_size_i,
  input  logic              bus_gnt_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              wr_en;

  assign wr_en = (state_q == WRITE) & rdy & bus_gnt_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Everything holds while rdy is low, so a stalled transfer resumes in place.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            if (req_size_i == 2'b11) begin
              err_d   = 1'b1;
              state_d = DONE;
            end else begin
              addr_d  = req_addr_i;
              data_d  = req_data_i;
              idx_d   = 2'd0;
              last_d  = (req_size_i == 2'b00) ? 2'd0 :
                        (req_size_i == 2'b01) ? 2'd1 : 2'd3;
              state_d = WRITE;
            end
          end
        end
        WRITE: begin
          if (bus_gnt_i) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == last_q) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o = (state_q == IDLE);
    busy_o      = (state_q != IDLE);
    mem_wr_o    = wr_en;
    mem_a_o     = '0;
    mem_dout_o  = '0;
    if (wr_en) begin
      mem_a_o    = addr_q + ADDR_W'(idx_q);
      mem_dout_o = data_q[{idx_q, 3'b000} +: 8];
    end
    done_o = (state_q == DONE) & rdy;
    err_o  = (state_q == DONE) & rdy & err_q;
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: vector table plus stall and reset sequences,
// with a byte-write scoreboard checked on every falling edge.
module tb_mem_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic [1:0]  req_size_i = '0;
  logic        bus_gnt_i = 1'b1;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o;
  logic        mem_wr_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  mem_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_size_i(req_size_i), .bus_gnt_i(bus_gnt_i),
    .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [63:0] rdy_pat;
    logic [63:0] gnt_pat;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [39:0] sbq[$];
  vec_t        tbl[7];
  vec_t        hv;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One falling edge plus bus-level checks against the scoreboard.
  task automatic tick();
    logic [39:0] e;
    @(negedge clk);
    if (!rst) begin
      if (mem_wr_o) begin
        check("wr_gated", 64'(rdy & bus_gnt_i), 64'd1);
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL strobe_unexpected: got addr %0h data %0h expected none",
                   mem_a_o, mem_dout_o);
        end else begin
          e = sbq.pop_front();
          check("strobe_addr", 64'(mem_a_o), 64'(e[39:8]));
          check("strobe_data", 64'(mem_dout_o), 64'(e[7:0]));
        end
      end else begin
        check("idle_addr", 64'(mem_a_o), 64'd0);
        check("idle_dout", 64'(mem_dout_o), 64'd0);
      end
      if (done_o) check("done_needs_rdy", 64'(rdy), 64'd1);
    end
  endtask

  // Entered and left at posedge+1.
  task automatic run_vec(input vec_t v);
    int n;
    int cyc;
    logic [31:0] a;
    n = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : (v.size == 2'd2) ? 4 : 0;
    rdy = 1'b1;
    bus_gnt_i = 1'b1;
    req_valid_i = 1'b1;
    req_addr_i = v.addr;
    req_data_i = v.data;
    req_size_i = v.size;
    for (int i = 0; i < n; i++) begin
      a = v.addr + 32'(i);
      sbq.push_back({a, v.data[8*i +: 8]});
    end
    tick();
    check("req_ready", 64'(req_ready_o), 64'd1);
    check("done_in_idle", 64'(done_o), 64'd0);
    @(posedge clk);
    #1;
    req_addr_i = $urandom;
    req_data_i = $urandom;
    req_size_i = 2'($urandom);
    cyc = 0;
    for (int k = 0; k < 60; k++) begin
      rdy = v.rdy_pat[k];
      bus_gnt_i = v.gnt_pat[k];
      tick();
      if (done_o) begin
        cyc = k + 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    req_valid_i = 1'b0;
    check("done_seen", 64'(cyc != 0), 64'd1);
    if (v.exp_lat != 0) check("latency", 64'(cyc), 64'(v.exp_lat));
    check("err_o", 64'(err_o), 64'(v.exp_err));
    check("bytes_left", 64'(sbq.size()), 64'd0);
    sbq.delete();
    @(posedge clk);
    #1;
    rdy = 1'b1;
    bus_gnt_i = 1'b1;
  endtask

  initial begin
    tbl[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 2'b10, '1, '1, 5, 1'b0};
    tbl[1] = '{32'h0003_0000, 32'h0000_0041, 2'b00, '1, '1, 2, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_1234, 2'b01, '1, '1, 3, 1'b0};
    tbl[3] = '{32'h0000_0400, 32'h1234_5678, 2'b11, '1, '1, 1, 1'b1};
    tbl[4] = '{32'h0000_1003, 32'hA5A5_5A5A, 2'b01, '1, '1, 3, 1'b0};
    tbl[5] = '{32'h0003_0000, 32'h0000_0000, 2'b00, '1, '1, 2, 1'b0};
    tbl[6] = '{32'hFFFF_FFFE, 32'h1122_3344, 2'b10, '1, '1, 5, 1'b0};

    #1;
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_wr", 64'(mem_wr_o), 64'd0);
    check("rst_addr", 64'(mem_a_o), 64'd0);
    check("rst_dout", 64'(mem_dout_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // rdy low for 3 cycles after the 2nd byte of a word
    hv = '{32'h0000_0200, 32'h0BAD_CAFE, 2'b10,
           64'hFFFF_FFFF_FFFF_FFE3, '1, 8, 1'b0};
    run_vec(hv);
    // grant pattern 1,0,0,1,1,0,1
    hv = '{32'h0000_0300, 32'h8765_4321, 2'b10,
           '1, 64'hFFFF_FFFF_FFFF_FFD9, 8, 1'b0};
    run_vec(hv);
    // rdy low while sitting in DONE
    hv = '{32'h0000_0500, 32'h0000_00C3, 2'b00,
           64'hFFFF_FFFF_FFFF_FFF9, '1, 4, 1'b0};
    run_vec(hv);

    // async reset after two bytes of a word
    req_valid_i = 1'b1;
    req_addr_i = 32'h0000_0600;
    req_data_i = 32'hCAFE_F00D;
    req_size_i = 2'b10;
    sbq.push_back({32'h0000_0600, 8'h0D});
    sbq.push_back({32'h0000_0601, 8'hF0});
    tick();
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    tick();
    @(posedge clk);
    #1;
    tick();
    check("rst_mid_bytes", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_wr", 64'(mem_wr_o), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    repeat (2) tick();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_rel_ready", 64'(req_ready_o), 64'd1);
    repeat (8) tick();
    check("rst_rel_idle", 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;
    run_vec(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
